calc_input_sequencer: RTL and testbench

CALC_INPUT_SEQUENCER -- requirements
Module: calc_input_sequencer

---
 rtl/calc_pkg.sv | 35 +++
 rtl/calc_input_sequencer.sv | 172 +++++++++++++++++
 tb/tb_calc_input_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator input path: key kinds, one-hot
// operator codes, sequencer state encoding and an operator legality helper.
package calc_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        KEY_DIGIT = 2'b00,
        KEY_OP    = 2'b01,
        KEY_EQ    = 2'b10,
        KEY_CLR   = 2'b11
    } key_kind_e;

    localparam logic [DATA_W-1:0] OP_ADD = 4'b0001;
    localparam logic [DATA_W-1:0] OP_SUB = 4'b0010;
    localparam logic [DATA_W-1:0] OP_MUL = 4'b0100;
    localparam logic [DATA_W-1:0] OP_DIV = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GOT_A  = 3'd1,
        ST_GOT_OP = 3'd2,
        ST_GOT_B  = 3'd3,
        ST_ISSUE  = 3'd4,
        ST_WAIT   = 3'd5
    } state_e;

    // Only the four one-hot codes name an operation.
    function automatic logic is_legal_op(input logic [DATA_W-1:0] code);
        return (code == OP_ADD) || (code == OP_SUB) ||
               (code == OP_MUL) || (code == OP_DIV);
    endfunction

endpackage

// File: rtl/calc_input_sequencer.sv
// Calculator key sequencer: collects operand/operator/equals keys, issues a
// one-cycle write to the downstream ALU, waits RESULT_LAT cycles and captures
// the result, which then becomes the first operand of a chained operation.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   key_valid/key_kind/key_val  one-cycle key strobe with kind and value
//   result_uncoded            ALU result input, sampled RESULT_LAT cycles after issue
//   alu_sel, wr_enable        one-cycle ALU write strobe (ISSUE state only)
//   first_nr, second_nr, operation  registered operands and one-hot operation
//   result, result_valid      captured result and its one-cycle valid pulse
//   busy                      high while an operation is in flight
//   err                       one-cycle pulse for a rejected key
module calc_input_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned RESULT_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [1:0]        key_kind,
    input  logic [DATA_W-1:0] key_val,
    input  logic [DATA_W-1:0] result_uncoded,
    output logic              alu_sel,
    output logic              wr_enable,
    output logic [DATA_W-1:0] first_nr,
    output logic [DATA_W-1:0] second_nr,
    output logic [DATA_W-1:0] operation,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              busy,
    output logic              err
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESULT_LAT - 1);

    state_e            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [DATA_W-1:0] first_d, second_d, op_d, result_d;
    logic              wr_d, rv_d, busy_d, err_d;

    key_kind_e kind;
    logic      is_dig, is_op, is_eq, is_clr, op_ok, cnt_zero;

    assign kind     = key_kind_e'(key_kind);
    assign is_dig   = key_valid && (kind == KEY_DIGIT);
    assign is_op    = key_valid && (kind == KEY_OP);
    assign is_eq    = key_valid && (kind == KEY_EQ);
    assign is_clr   = key_valid && (kind == KEY_CLR);
    assign op_ok    = is_legal_op(key_val);
    assign cnt_zero = (cnt == '0);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; clear overrides everything, including in-flight ops.
    always_comb begin
        state_next = state;
        if (is_clr) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (is_dig) state_next = ST_GOT_A;
                ST_GOT_A:  if (is_op && op_ok) state_next = ST_GOT_OP;
                ST_GOT_OP: if (is_dig) state_next = ST_GOT_B;
                ST_GOT_B:  if (is_eq) state_next = ST_ISSUE;
                ST_ISSUE:  state_next = ST_WAIT;
                ST_WAIT:   if (cnt_zero) state_next = ST_GOT_A;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    // Output/datapath next values; registered below.
    always_comb begin
        first_d  = first_nr;
        second_d = second_nr;
        op_d     = operation;
        result_d = result;
        cnt_d    = cnt;
        rv_d     = 1'b0;
        err_d    = 1'b0;
        if (is_clr) begin
            first_d  = '0;
            second_d = '0;
            op_d     = '0;
            cnt_d    = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_dig) first_d = key_val;
                    if (is_op)  err_d   = 1'b1;
                end
                ST_GOT_A: begin
                    if (is_dig) first_d = key_val;
                    if (is_op) begin
                        if (op_ok) op_d  = key_val;
                        else       err_d = 1'b1;
                    end
                end
                ST_GOT_OP: begin
                    if (is_dig) second_d = key_val;
                    if (is_op) begin
                        if (op_ok) op_d  = key_val;
                        else       err_d = 1'b1;
                    end
                    if (is_eq) err_d = 1'b1;
                end
                ST_GOT_B: begin
                    if (is_dig) second_d = key_val;
                    if (is_op)  err_d    = 1'b1;
                end
                ST_ISSUE: begin
                    cnt_d = CNT_LOAD;
                    if (key_valid) err_d = 1'b1;
                end
                ST_WAIT: begin
                    if (key_valid) err_d = 1'b1;
                    if (cnt_zero) begin
                        // Result seeds the first operand of a chained operation.
                        result_d = result_uncoded;
                        rv_d     = 1'b1;
                        first_d  = result_uncoded;
                        second_d = '0;
                        op_d     = '0;
                    end else begin
                        cnt_d = cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
        // Strobes are registered, so they follow the state being entered.
        wr_d   = (state_next == ST_ISSUE);
        busy_d = (state_next == ST_ISSUE) || (state_next == ST_WAIT);
    end

    // Operand, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_nr     <= '0;
            second_nr    <= '0;
            operation    <= '0;
            result       <= '0;
            cnt          <= '0;
            alu_sel      <= 1'b0;
            wr_enable    <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            first_nr     <= first_d;
            second_nr    <= second_d;
            operation    <= op_d;
            result       <= result_d;
            cnt          <= cnt_d;
            alu_sel      <= wr_d;
            wr_enable    <= wr_d;
            result_valid <= rv_d;
            busy         <= busy_d;
            err          <= err_d;
        end
    end

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Bench for calc_input_sequencer: directed scenarios followed by random key
// traffic, every cycle compared against a transaction-level model.
module tb_calc_input_sequencer;

    localparam int unsigned LAT = 3;
    localparam int K_DIG = 0;
    localparam int K_OP  = 1;
    localparam int K_EQ  = 2;
    localparam int K_CLR = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_valid = 1'b0;
    logic [1:0] key_kind = 2'b00;
    logic [3:0] key_val = 4'h0;
    logic [3:0] result_uncoded = 4'h0;
    logic       alu_sel, wr_enable, result_valid, busy, err;
    logic [3:0] first_nr, second_nr, operation, result;

    calc_input_sequencer #(.RESULT_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .key_valid(key_valid), .key_kind(key_kind), .key_val(key_val),
        .result_uncoded(result_uncoded),
        .alu_sel(alu_sel), .wr_enable(wr_enable),
        .first_nr(first_nr), .second_nr(second_nr), .operation(operation),
        .result(result), .result_valid(result_valid),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Model: what the calculator holds and how many edges remain until the
    // in-flight result is captured (0 = nothing in flight).
    int m_a, m_b, m_op, m_res, m_busy;
    bit has_a, has_op, has_b;
    bit e_wr, e_rv, e_err;

    function automatic logic [3:0] alu(input int a, input int b, input int op);
        case (op)
            1: return 4'((a + b) & 15);
            2: return 4'((a - b) & 15);
            4: return 4'((a * b) & 15);
            8: return (b == 0) ? 4'hF : 4'(a / b);
            default: return 4'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_busy = 0;
        has_a = 0; has_op = 0; has_b = 0;
        e_wr = 0; e_rv = 0; e_err = 0;
    endtask

    task automatic model_edge(input bit kv, input int kind, input int val, input int ru);
        bit legal;
        legal = (val == 1) || (val == 2) || (val == 4) || (val == 8);
        e_wr = 0; e_rv = 0; e_err = 0;
        if (kv && kind == K_CLR) begin
            m_a = 0; m_b = 0; m_op = 0; m_busy = 0;
            has_a = 0; has_op = 0; has_b = 0;
        end else if (m_busy > 0) begin
            if (kv) e_err = 1;
            m_busy--;
            if (m_busy == 0) begin
                m_res = ru; m_a = ru; m_b = 0; m_op = 0;
                has_a = 1; has_op = 0; has_b = 0;
                e_rv = 1;
            end
        end else if (kv) begin
            case (kind)
                K_DIG: begin
                    if (!has_a)       begin m_a = val; has_a = 1; end
                    else if (!has_op) m_a = val;
                    else              begin m_b = val; has_b = 1; end
                end
                K_OP: begin
                    if (!has_a || has_b || !legal) e_err = 1;
                    else begin m_op = val; has_op = 1; end
                end
                default: begin
                    if (has_b)       begin m_busy = LAT + 1; e_wr = 1; end
                    else if (has_op) e_err = 1;
                end
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/first_nr"},     32'(first_nr),     32'(m_a));
        chk({tag, "/second_nr"},    32'(second_nr),    32'(m_b));
        chk({tag, "/operation"},    32'(operation),    32'(m_op));
        chk({tag, "/result"},       32'(result),       32'(m_res));
        chk({tag, "/wr_enable"},    32'(wr_enable),    32'(e_wr));
        chk({tag, "/alu_sel"},      32'(alu_sel),      32'(e_wr));
        chk({tag, "/result_valid"}, 32'(result_valid), 32'(e_rv));
        chk({tag, "/err"},          32'(err),          32'(e_err));
        chk({tag, "/busy"},         32'(busy),         32'(m_busy > 0));
    endtask

    // One clock: drive at negedge, advance model at posedge, compare after.
    task automatic step(input string tag, input bit kv, input int kind, input int val);
        @(negedge clk);
        key_valid      = kv;
        key_kind       = 2'(kind);
        key_val        = 4'(val);
        result_uncoded = alu(m_a, m_b, m_op);
        @(posedge clk);
        model_edge(kv, kind, val, int'(result_uncoded));
        #1;
        check_all(tag);
    endtask

    task automatic key(input string tag, input int kind, input int val);
        step(tag, 1'b1, kind, val);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, K_DIG, 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "/first_nr"},     32'(first_nr),     32'd0);
        chk({tag, "/second_nr"},    32'(second_nr),    32'd0);
        chk({tag, "/operation"},    32'(operation),    32'd0);
        chk({tag, "/result"},       32'(result),       32'd0);
        chk({tag, "/wr_enable"},    32'(wr_enable),    32'd0);
        chk({tag, "/alu_sel"},      32'(alu_sel),      32'd0);
        chk({tag, "/result_valid"}, 32'(result_valid), 32'd0);
        chk({tag, "/err"},          32'(err),          32'd0);
        chk({tag, "/busy"},         32'(busy),         32'd0);
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #12;
        check_zero_outputs("reset");
        @(posedge clk); #2 rst = 1'b0;

        // 3 + 5 =, captured four cycles after the equals strobe.
        key("first_key", K_DIG, 3);
        chk("first_key_taken", 32'(first_nr), 32'd3);
        key("add", K_OP, 1);
        key("digit5", K_DIG, 5);
        key("eq1", K_EQ, 0);
        chk("eq1_wr", 32'(wr_enable), 32'd1);
        chk("eq1_sel", 32'(alu_sel), 32'd1);
        chk("eq1_ops", {20'd0, first_nr, second_nr, operation}, {20'd0, 4'd3, 4'd5, 4'b0001});
        idle("lat1", 1);
        chk("wr_one_cycle", 32'(wr_enable), 32'd0);
        idle("lat1", 2);
        chk("rv_not_early", 32'(result_valid), 32'd0);
        idle("lat1", 1);
        chk("rv_at_4", 32'(result_valid), 32'd1);
        chk("result_8", 32'(result), 32'd8);
        chk("chain_first", 32'(first_nr), 32'd8);
        idle("rv_pulse", 1);
        chk("rv_one_cycle", 32'(result_valid), 32'd0);

        // Chained: 8 - 2 =.
        key("sub", K_OP, 2);
        key("digit2", K_DIG, 2);
        key("eq2", K_EQ, 0);
        chk("eq2_ops", {19'd0, wr_enable, first_nr, second_nr, operation},
            {19'd0, 1'b1, 4'd8, 4'd2, 4'b0010});
        idle("lat2", 4);
        chk("result_6", 32'(result), 32'd6);

        // Illegal operator in GOT_A, then a legal one still accepted.
        key("clr1", K_CLR, 0);
        key("eq_idle", K_EQ, 0);
        chk("eq_idle_no_err", 32'(err), 32'd0);
        key("digit7", K_DIG, 7);
        key("bad_op", K_OP, 3);
        chk("bad_op_err", 32'(err), 32'd1);
        chk("bad_op_opr", 32'(operation), 32'd0);
        key("mul", K_OP, 4);
        chk("mul_taken", 32'(operation), 32'd4);
        key("eq_gotop", K_EQ, 0);
        chk("eq_gotop_err", 32'(err), 32'd1);

        // Digit during WAIT: err, timing unchanged; 7*5 = 35 -> 3.
        key("digit5b", K_DIG, 5);
        key("eq3", K_EQ, 0);
        key("dig_wait", K_DIG, 9);
        chk("dig_wait_err", 32'(err), 32'd1);
        idle("lat3", 2);
        chk("rv_not_early3", 32'(result_valid), 32'd0);
        idle("lat3", 1);
        chk("rv3", 32'(result_valid), 32'd1);
        chk("result_3", 32'(result), 32'd3);

        // Clear during WAIT aborts the operation.
        key("add2", K_OP, 1);
        key("digit1", K_DIG, 1);
        key("eq4", K_EQ, 0);
        idle("wait4", 1);
        key("clr_wait", K_CLR, 0);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_first", 32'(first_nr), 32'd0);
        idle("after_clr", 6);

        // Reset during WAIT aborts the operation.
        key("d2", K_DIG, 2);
        key("add3", K_OP, 1);
        key("d2b", K_DIG, 2);
        key("eq5", K_EQ, 0);
        idle("wait5", 1);
        @(negedge clk);
        key_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_zero_outputs("rst_wait");
        model_reset();
        @(posedge clk); #2 rst = 1'b0;
        idle("after_rst", 6);

        // Random key traffic against the model.
        for (int i = 0; i < 800; i++) begin
            int r, kind, val;
            bit kv;
            kv = ($urandom_range(0, 3) != 0);
            r  = int'($urandom_range(0, 99));
            kind = (r < 45) ? K_DIG : (r < 75) ? K_OP : (r < 94) ? K_EQ : K_CLR;
            val  = int'($urandom_range(0, 15));
            if (kind == K_OP && $urandom_range(0, 9) < 7) val = 1 << $urandom_range(0, 3);
            step("rand", kv, kind, val);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
